// File: rtl/ipv4_frame_gen.sv
// rtl/ipv4_frame_gen.sv - Avalon-ST Ethernet/IPv4 test frame generator
//
// Produces frames of 32-bit words: 2-byte pad + MAC header, 0..2 VLAN tags,
// IPv4 header with per-frame identification and checksum, counting payload.
//
// Ports:
//   sys_clk      clock
//   reset        asynchronous active-high reset
//   enable       level; frames start only while high
//   n_frames     frames per enable burst, sampled on enable rise (0 = unlimited)
//   out_data     stream word (zero when out_valid is low)
//   out_valid    word valid
//   out_sop      start of packet, first word only
//   out_eop      end of packet, last payload word only
//   out_ready    sink ready, ready latency 0
//   busy         high from first sop to last eop of a burst, gaps included
//   frames_sent  count of accepted eop words
//   dups_sent    count of frames scheduled with a repeated ID
`timescale 1ns/1ps
module ipv4_frame_gen #(
  parameter int unsigned N_VLAN        = 0,
  parameter int unsigned PAYLOAD_WORDS = 4,
  parameter logic [15:0] IP_ID_START   = 16'h0000,
  parameter logic [15:0] IP_ID_STEP    = 16'h0001,
  parameter int unsigned REPEAT_EVERY  = 0,
  parameter int unsigned GAP_CYCLES    = 2,
  parameter logic [47:0] DST_MAC       = 48'h0200_0000_0002,
  parameter logic [47:0] SRC_MAC       = 48'h0200_0000_0001,
  parameter logic [31:0] SRC_IP        = 32'hC0A8_0001,
  parameter logic [31:0] DST_IP        = 32'hC0A8_0002
) (
  input  logic        sys_clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [15:0] n_frames,
  output logic [31:0] out_data,
  output logic        out_valid,
  output logic        out_sop,
  output logic        out_eop,
  input  logic        out_ready,
  output logic        busy,
  output logic [31:0] frames_sent,
  output logic [31:0] dups_sent
);

  localparam logic [10:0] IP_BASE = 11'(4 + N_VLAN);
  localparam logic [10:0] HDR_W   = 11'(9 + N_VLAN);
  localparam logic [10:0] LAST_W  = 11'(9 + N_VLAN + PAYLOAD_WORDS - 1);
  localparam logic [15:0] TOTLEN  = 16'(20 + 4 * PAYLOAD_WORDS);
  localparam logic [15:0] ET0     = (N_VLAN == 0) ? 16'h0800 :
                                    (N_VLAN == 1) ? 16'h8100 : 16'h9100;

  typedef enum logic [1:0] {S_IDLE, S_HDR, S_PAY, S_GAP} state_t;

  // One's-complement header checksum with the checksum field taken as zero.
  function automatic logic [15:0] hdr_csum(input logic [15:0] id);
    logic [19:0] s;
    s = 20'h04500 + 20'(TOTLEN) + 20'(id) + 20'h04000 + 20'h04011
      + 20'(SRC_IP[31:16]) + 20'(SRC_IP[15:0])
      + 20'(DST_IP[31:16]) + 20'(DST_IP[15:0]);
    s = 20'(s[15:0]) + 20'(s[19:16]);
    s = 20'(s[15:0]) + 20'(s[19:16]);
    return ~s[15:0];
  endfunction

  state_t      state_q, state_d;
  logic [10:0] wcnt_q, wcnt_d;
  logic [7:0]  gcnt_q, gcnt_d;
  logic [15:0] id_q, id_d;
  logic [15:0] csum_q;
  logic [31:0] kmod_q, kmod_d;
  logic [31:0] frames_q, frames_d;
  logic [31:0] dups_q, dups_d;
  logic [15:0] rem_q, rem_d;
  logic        unlim_q, unlim_d;
  logic        en_q;

  logic        accept, last_word, rise, unlim_eff, repeat_next;
  logic [15:0] rem_eff;
  logic [31:0] kmod_nxt;
  logic [10:0] ip_idx;

  assign accept    = out_valid & out_ready;
  assign last_word = (wcnt_q == LAST_W);
  // A rising enable reloads the burst length in the same cycle it is seen.
  assign rise      = enable & ~en_q;
  assign rem_eff   = rise ? n_frames : rem_q;
  assign unlim_eff = rise ? (n_frames == 16'd0) : unlim_q;

  // kmod tracks k % REPEAT_EVERY for the frame index k about to follow.
  always_comb begin
    kmod_nxt    = 32'd0;
    repeat_next = 1'b0;
    if (REPEAT_EVERY != 0) begin
      kmod_nxt    = (kmod_q == 32'(REPEAT_EVERY - 1)) ? 32'd0 : kmod_q + 32'd1;
      repeat_next = (kmod_nxt == 32'(REPEAT_EVERY - 1));
    end
  end

  always_comb begin
    state_d  = state_q;
    wcnt_d   = wcnt_q;
    gcnt_d   = gcnt_q;
    id_d     = id_q;
    kmod_d   = kmod_q;
    frames_d = frames_q;
    dups_d   = dups_q;
    rem_d    = rem_eff;
    unlim_d  = unlim_eff;
    case (state_q)
      S_IDLE: begin
        if (enable && (unlim_eff || rem_eff != 16'd0)) begin
          state_d = S_HDR;
          wcnt_d  = 11'd0;
        end
      end
      S_HDR, S_PAY: begin
        if (accept) begin
          wcnt_d = wcnt_q + 11'd1;
          if (wcnt_q == HDR_W - 11'd1) state_d = S_PAY;
          if (last_word) begin
            wcnt_d   = 11'd0;
            frames_d = frames_q + 32'd1;
            kmod_d   = kmod_nxt;
            if (repeat_next) dups_d = dups_q + 32'd1;
            else             id_d   = id_q + IP_ID_STEP;
            if (!unlim_eff && rem_eff != 16'd0) rem_d = rem_eff - 16'd1;
            if (GAP_CYCLES != 0) begin
              state_d = S_GAP;
              gcnt_d  = 8'(GAP_CYCLES - 1);
            end else begin
              state_d = (enable && (unlim_eff || rem_d != 16'd0)) ? S_HDR : S_IDLE;
            end
          end
        end
      end
      S_GAP: begin
        if (gcnt_q == 8'd0) state_d = (enable && (unlim_eff || rem_eff != 16'd0)) ? S_HDR : S_IDLE;
        else                gcnt_d  = gcnt_q - 8'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      wcnt_q   <= 11'd0;
      gcnt_q   <= 8'd0;
      id_q     <= IP_ID_START;
      csum_q   <= hdr_csum(IP_ID_START);
      kmod_q   <= 32'd0;
      frames_q <= 32'd0;
      dups_q   <= 32'd0;
      rem_q    <= 16'd0;
      unlim_q  <= 1'b0;
      en_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      wcnt_q   <= wcnt_d;
      gcnt_q   <= gcnt_d;
      id_q     <= id_d;
      // Follows the next ID so it is settled long before the checksum word.
      csum_q   <= hdr_csum(id_d);
      kmod_q   <= kmod_d;
      frames_q <= frames_d;
      dups_q   <= dups_d;
      rem_q    <= rem_d;
      unlim_q  <= unlim_d;
      en_q     <= enable;
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign out_valid   = (state_q == S_HDR) || (state_q == S_PAY);
  assign out_sop     = out_valid && (wcnt_q == 11'd0);
  assign out_eop     = (state_q == S_PAY) && last_word;
  assign frames_sent = frames_q;
  assign dups_sent   = dups_q;

  always_comb begin
    out_data = 32'd0;
    ip_idx   = wcnt_q - IP_BASE;
    if (state_q == S_PAY) begin
      out_data = {frames_q[15:0], 16'(wcnt_q - HDR_W)};
    end else if (state_q == S_HDR) begin
      if (wcnt_q < 11'd4) begin
        case (wcnt_q[1:0])
          2'd0:    out_data = {16'h0000, DST_MAC[47:32]};
          2'd1:    out_data = DST_MAC[31:0];
          2'd2:    out_data = SRC_MAC[47:16];
          default: out_data = {SRC_MAC[15:0], ET0};
        endcase
      end else if (wcnt_q < IP_BASE) begin
        out_data = {16'h0001, (wcnt_q == IP_BASE - 11'd1) ? 16'h0800 : 16'h8100};
      end else begin
        case (ip_idx[2:0])
          3'd0:    out_data = {16'h4500, TOTLEN};
          3'd1:    out_data = {id_q, 16'h4000};
          3'd2:    out_data = {16'h4011, csum_q};
          3'd3:    out_data = SRC_IP;
          default: out_data = DST_IP;
        endcase
      end
    end
  end

endmodule
